// File: rtl/cv32e40p_dft_pkg.sv
// Shared DFT types and default LFSR polynomials
// for the CV32E40P logic-BIST controller.
package cv32e40p_dft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE,
        UNLOAD,
        DONE
    } lbist_state_e;

    localparam logic [31:0] PRPG_POLY_DEF = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY_DEF = 32'h8020_0003;

endpackage

// File: rtl/cv32e40p_dft_lfsr.sv
// Galois LFSR with parallel input; used as PRPG (data=0)
// and as MISR (data=scan-out).
module cv32e40p_dft_lfsr #(
    parameter int            W    = 32,
    parameter logic [W-1:0]  POLY = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         advance,
    input  logic [W-1:0] data,
    output logic [W-1:0] state
);

    logic [W-1:0] q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (advance) begin
            q <= {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ data;
        end
    end

    assign state = q;

endmodule

// File: rtl/cv32e40p_lbist_ctrl.sv
// Logic-BIST scan sequencer: PRPG-driven shift/capture for N chains.
// Define CV32E40P_LBIST_MISR_EN to build the output-compacting MISR.
module cv32e40p_lbist_ctrl
    import cv32e40p_dft_pkg::*;
#(
    parameter int                NUM_OF_CHAINS = 5,
    parameter int                CHAIN_LEN     = 64,
    parameter int                PRPG_W        = 32,
    parameter logic [PRPG_W-1:0] PRPG_POLY     = PRPG_W'(PRPG_POLY_DEF),
    parameter int                MISR_W        = 32,
    parameter logic [MISR_W-1:0] MISR_POLY     = MISR_W'(MISR_POLY_DEF),
    parameter int                PAT_W         = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     test_mode_i,
    input  logic                     start_i,
    input  logic [PAT_W-1:0]         num_patterns_i,
    input  logic [PRPG_W-1:0]        seed_i,
    output logic                     se_o,
    output logic [NUM_OF_CHAINS-1:0] si_o,
    input  logic [NUM_OF_CHAINS-1:0] so_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [PAT_W-1:0]         pattern_cnt_o,
    output logic [MISR_W-1:0]        signature_o
);

    localparam int SH_W = $clog2(CHAIN_LEN + 1);

    lbist_state_e      state_q, state_d;
    logic [PAT_W-1:0]  num_pat_q, pat_cnt_q;
    logic [SH_W-1:0]   sh_cnt_q;
    logic [PRPG_W-1:0] prpg, prpg_seed;
    logic              accept, active, shifting;
    logic              sh_last, cap_last;

    assign accept    = (state_q == IDLE) && start_i && test_mode_i;
    // a run in progress with test mode still granted; no updates on abort
    assign active    = test_mode_i && (state_q != IDLE);
    assign shifting  = active && (state_q == SHIFT || state_q == UNLOAD);
    assign sh_last   = sh_cnt_q == SH_W'(CHAIN_LEN - 1);
    assign cap_last  = PAT_W'(pat_cnt_q + 1'b1) == num_pat_q;
    assign prpg_seed = (seed_i == '0) ? PRPG_W'(1) : seed_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && !test_mode_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = LOAD;
                LOAD:    state_d = (num_pat_q == '0) ? DONE : SHIFT;
                SHIFT:   if (sh_last) state_d = CAPTURE;
                CAPTURE: state_d = cap_last ? UNLOAD : SHIFT;
                UNLOAD:  if (sh_last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            num_pat_q <= '0;
            pat_cnt_q <= '0;
            sh_cnt_q  <= '0;
        end else begin
            if (accept) begin
                num_pat_q <= num_patterns_i;
            end
            if (active && state_q == LOAD) begin
                pat_cnt_q <= '0;
                sh_cnt_q  <= '0;
            end
            if (shifting) begin
                sh_cnt_q <= sh_last ? '0 : sh_cnt_q + 1'b1;
            end
            if (active && state_q == CAPTURE) begin
                pat_cnt_q <= pat_cnt_q + 1'b1;
            end
        end
    end

    // seeded at start acceptance: si_o is 0 during LOAD, so this is
    // indistinguishable from seeding in LOAD and saves a seed register
    cv32e40p_dft_lfsr #(
        .W    (PRPG_W),
        .POLY (PRPG_POLY)
    ) u_prpg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (accept),
        .seed    (prpg_seed),
        .advance (active && state_q == SHIFT),
        .data    ('0),
        .state   (prpg)
    );

`ifdef CV32E40P_LBIST_MISR_EN
    logic [MISR_W-1:0] so_ext;

    always_comb begin
        so_ext = '0;
        so_ext[NUM_OF_CHAINS-1:0] = so_i;
    end

    // first pattern's shift unloads unknown power-up chain contents
    cv32e40p_dft_lfsr #(
        .W    (MISR_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (active && state_q == LOAD),
        .seed    ('0),
        .advance (shifting && (state_q == UNLOAD || pat_cnt_q != '0)),
        .data    (so_ext),
        .state   (signature_o)
    );
`else
    logic unused_misr;
    assign unused_misr = ^{so_i, MISR_POLY};
    assign signature_o = '0;
`endif

    logic unused_prpg;
    assign unused_prpg = ^prpg;

    assign se_o          = (state_q == SHIFT) || (state_q == UNLOAD);
    assign si_o          = (state_q == SHIFT) ? prpg[NUM_OF_CHAINS-1:0] : '0;
    assign busy_o        = state_q != IDLE;
    assign done_o        = state_q == DONE;
    assign pattern_cnt_o = pat_cnt_q;

endmodule

// File: tb/tb_cv32e40p_lbist_ctrl.sv
// Scoreboard bench for cv32e40p_lbist_ctrl (2 chains x 4 flops)
// with a loopback chain model and a pattern-level reference model.
module tb_cv32e40p_lbist_ctrl;

    localparam int N = 2;
    localparam int L = 4;
    localparam logic [31:0] PP = 32'h8020_0003;
    localparam logic [31:0] MP = 32'h8020_0003;

    typedef struct {
        logic [31:0] done_cyc;
        logic [15:0] pcnt;
        logic [31:0] sig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i, test_mode_i, start_i;
    logic [15:0] num_patterns_i;
    logic [31:0] seed_i;
    logic        se_o, busy_o, done_o;
    logic [N-1:0] si_o, so_i;
    logic [15:0] pattern_cnt_o;
    logic [31:0] signature_o;

    logic [L-1:0] chain [N];
    logic [31:0]  cyc = 0;
    bit           mon_on = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    exp_t         sb[$];
    logic [N-1:0] si_q[$];

    always #5 clk = ~clk;

    cv32e40p_lbist_ctrl #(
        .NUM_OF_CHAINS (N),
        .CHAIN_LEN     (L)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .test_mode_i    (test_mode_i),
        .start_i        (start_i),
        .num_patterns_i (num_patterns_i),
        .seed_i         (seed_i),
        .se_o           (se_o),
        .si_o           (si_o),
        .so_i           (so_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pattern_cnt_o  (pattern_cnt_o),
        .signature_o    (signature_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // each chain is a plain L-deep shift register looping si_o back to so_i
    always @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (rst_i) chain[c] <= '0;
            else if (se_o) chain[c] <= {chain[c][L-2:0], si_o[c]};
        end
    end

    always_comb begin
        for (int c = 0; c < N; c++) so_i[c] = chain[c][L-1];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] v,
                                          input logic [31:0] poly);
        return {v[30:0], 1'b0} ^ (v[31] ? poly : 32'h0);
    endfunction

    // monitor: pops expected scan-in per SE cycle and a result per done_o
    always @(negedge clk) begin
        if (mon_on) begin
            logic [N-1:0] ex;
            exp_t e;
            if (se_o) begin
                ex = (si_q.size() > 0) ? si_q.pop_front() : 'x;
                chk("si", 64'(si_o), 64'(ex));
            end else if (busy_o) begin
                chk("si_noshift", 64'(si_o), 64'h0);
            end
            if (done_o) begin
                if (sb.size() > 0) e = sb.pop_front();
                else e = '{done_cyc: 'x, pcnt: 'x, sig: 'x};
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                chk("pattern_cnt", 64'(pattern_cnt_o), 64'(e.pcnt));
                chk("signature", 64'(signature_o), 64'(e.sig));
                chk("si_left", 64'(si_q.size()), 64'h0);
                chk("done_busy", 64'(busy_o), 64'h1);
            end
        end
    end

    task automatic run(input int p, input logic [31:0] seed, input bit poke);
        exp_t        e;
        logic [31:0] pr, sig;
        int          budget;
        pr  = (seed == 0) ? 32'h1 : seed;
        sig = 0;
        // every scan-in bit reappears at so_i L shifts later; all shifts
        // after the first pattern's are compacted, i.e. every PRPG word
        for (int j = 0; j < p * L; j++) begin
            si_q.push_back(pr[N-1:0]);
            sig = lstep(sig, MP) ^ {30'h0, pr[N-1:0]};
            pr  = lstep(pr, PP);
        end
        if (p > 0) for (int j = 0; j < L; j++) si_q.push_back('0);
`ifndef CV32E40P_LBIST_MISR_EN
        sig = 0;
`endif
        start_i = 1; num_patterns_i = 16'(p); seed_i = seed;
        @(posedge clk); #1;
        start_i = 0;
        e.done_cyc = (p == 0) ? cyc + 1 : cyc + 32'(p * (L + 1) + L + 1);
        e.pcnt = 16'(p);
        e.sig = sig;
        sb.push_back(e);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            start_i = 1; num_patterns_i = 16'($urandom); seed_i = $urandom;
            @(posedge clk); #1;
            start_i = 0;
        end
        budget = p * (L + 1) + L + 10;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk("run_timeout", 64'(sb.size()), 64'h0);
        sb.delete();
        si_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        bit saw;
        int p;
        rst_i = 1; test_mode_i = 1; start_i = 0;
        num_patterns_i = 0; seed_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_se", 64'(se_o), 64'h0);
        chk("rst_si", 64'(si_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_done", 64'(done_o), 64'h0);
        chk("rst_pcnt", 64'(pattern_cnt_o), 64'h0);
        chk("rst_sig", 64'(signature_o), 64'h0);
        rst_i = 0;
        @(posedge clk); #1;
        mon_on = 1;

        run(3, 32'h1, 0);
        run(0, $urandom, 0);
        chk("p0_sig", 64'(signature_o), 64'h0);
        run(3, 32'h0, 0);
        run(5, $urandom, 0);
        for (int i = 0; i < 8; i++) begin
            p = $urandom_range(0, 6);
            run(p, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                (p >= 2) && ($urandom_range(0, 1) == 1));
        end
        mon_on = 0;

        // abort in the second SHIFT cycle
        start_i = 1; num_patterns_i = 3; seed_i = $urandom;
        @(posedge clk); #1;
        start_i = 0;
        repeat (2) @(posedge clk);
        #1;
        test_mode_i = 0;
        @(posedge clk); #1;
        chk("abort_busy", 64'(busy_o), 64'h0);
        chk("abort_se", 64'(se_o), 64'h0);
        chk("abort_pcnt", 64'(pattern_cnt_o), 64'h0);
        saw = 0;
        repeat (6) begin
            @(posedge clk); #1;
            saw |= done_o;
        end
        chk("abort_no_done", 64'(saw), 64'h0);

        // start without test mode is ignored
        start_i = 1; num_patterns_i = 2;
        @(posedge clk); #1;
        start_i = 0;
        chk("tm_low_busy", 64'(busy_o), 64'h0);
        test_mode_i = 1;
        @(posedge clk); #1;

        // reset in the second UNLOAD cycle (cycle 8 of a 1-pattern run)
        start_i = 1; num_patterns_i = 1; seed_i = $urandom;
        @(posedge clk); #1;
        start_i = 0;
        repeat (7) @(posedge clk);
        #1;
        chk("unload_se", 64'(se_o), 64'h1);
        chk("unload_si", 64'(si_o), 64'h0);
        rst_i = 1;
        @(posedge clk); #1;
        chk("urst_outs", 64'({se_o, si_o, busy_o, done_o}), 64'h0);
        chk("urst_pcnt", 64'(pattern_cnt_o), 64'h0);
        chk("urst_sig", 64'(signature_o), 64'h0);
        rst_i = 0;
        @(posedge clk); #1;

        mon_on = 1;
        run(2, $urandom, 1);
        run(1, $urandom, 0);
        mon_on = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
